exmem_stage: RTL

- EX/MEM pipeline register and memory-stage controller, directly downstream of the ID/EX latch and the execute stage.
- Latches execute results and the control bits carried through ID/EX, and drives the data-cache request/dhit handshake.
- Stalls the pipeline while a data access is outstanding.
- Implements the LL/SC link register with snoop invalidation.
- Produces the MEM/WB register contents consumed by writeback.

---
 rtl/exmem_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register and memory-stage controller: data-cache request/dhit
// handshake, pipeline stall, LL/SC link register and the MEM/WB latch.
module exmem_stage #(
    parameter int WORD_W   = 32,
    parameter int REG_W    = 5,
    parameter int LINK_LSB = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              writeEN,
    input  logic              flush,
    input  logic [WORD_W-1:0] alu_in,
    input  logic [WORD_W-1:0] store_in,
    input  logic              dMemREN_in,
    input  logic              dMemWEN_in,
    input  logic              Atomic_in,
    input  logic              MemToReg_in,
    input  logic              regWEN_in,
    input  logic [REG_W-1:0]  writeReg_in,
    input  logic              Halt_in,
    input  logic [WORD_W-1:0] pcplus4_in,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] wb_wdat,
    output logic              wb_regWEN,
    output logic [REG_W-1:0]  wb_writeReg,
    output logic [WORD_W-1:0] wb_pcplus4,
    output logic              halted
);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALTED} state_e;

    typedef struct packed {
        logic              ren;
        logic              wen;
        logic              atomic;
        logic              memtoreg;
        logic              regwen;
        logic [REG_W-1:0]  write_reg;
        logic              halt;
        logic [WORD_W-1:0] alu;
        logic [WORD_W-1:0] store;
        logic [WORD_W-1:0] pcplus4;
    } mreg_t;

    typedef struct packed {
        logic [WORD_W-1:0] wdat;
        logic              regwen;
        logic [REG_W-1:0]  write_reg;
        logic [WORD_W-1:0] pcplus4;
    } wbreg_t;

    state_e            state_q, state_d;
    mreg_t             m_q, m_d, ex;
    wbreg_t            wb_q, wb_d;
    logic              link_valid_q, link_valid_d;
    logic [WORD_W-1:0] link_addr_q, link_addr_d;

    logic halted_st, snoop_match, sc_ok, is_sc;

    function automatic logic same_word(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
        return a[WORD_W-1:LINK_LSB] == b[WORD_W-1:LINK_LSB];
    endfunction

    assign ex = '{ren: dMemREN_in, wen: dMemWEN_in, atomic: Atomic_in,
                  memtoreg: MemToReg_in, regwen: regWEN_in, write_reg: writeReg_in,
                  halt: Halt_in, alu: alu_in, store: store_in, pcplus4: pcplus4_in};

    assign halted_st   = (state_q == ST_HALTED);
    assign snoop_match = snoop_inv && same_word(snoop_addr, link_addr_q);
    // An invalidation landing in the same cycle as the SC already defeats it.
    assign sc_ok       = link_valid_q && same_word(link_addr_q, m_q.alu) && !snoop_match;
    assign is_sc       = m_q.wen && m_q.atomic;

    assign dmemREN   = m_q.ren && !halted_st;
    assign dmemWEN   = m_q.wen && (!m_q.atomic || sc_ok) && !halted_st;
    assign dmemaddr  = m_q.alu;
    assign dmemstore = m_q.store;
    assign mem_stall = (dmemREN || dmemWEN) && !dhit;

    assign wb_wdat     = wb_q.wdat;
    assign wb_regWEN   = wb_q.regwen;
    assign wb_writeReg = wb_q.write_reg;
    assign wb_pcplus4  = wb_q.pcplus4;
    assign halted      = halted_st;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        m_d          = '0;
        wb_d         = '0;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;

        unique case (state_q)
            ST_RUN, ST_WAIT: begin
                if (m_q.halt && !mem_stall) state_d = ST_HALTED;
                else if (mem_stall)         state_d = ST_WAIT;
                else                        state_d = ST_RUN;
            end
            default: state_d = ST_HALTED;
        endcase

        if (mem_stall)    m_d = m_q;
        else if (flush)   m_d = '0;
        else if (writeEN) m_d = ex;

        if (!mem_stall && !halted_st) begin
            wb_d.regwen    = m_q.regwen;
            wb_d.write_reg = m_q.write_reg;
            wb_d.pcplus4   = m_q.pcplus4;
            if (is_sc)              wb_d.wdat = {{(WORD_W-1){1'b0}}, sc_ok};
            else if (m_q.memtoreg)  wb_d.wdat = dmemload;
            else                    wb_d.wdat = m_q.alu;
        end

        // Clears first, then an LL completion so it wins over a same-edge snoop.
        if (snoop_match) link_valid_d = 1'b0;
        if (!mem_stall && !halted_st) begin
            if (is_sc) link_valid_d = 1'b0;
            if (dmemWEN && !m_q.atomic && same_word(m_q.alu, link_addr_q)) link_valid_d = 1'b0;
            if (dmemREN && m_q.atomic) begin
                link_valid_d = 1'b1;
                link_addr_d  = m_q.alu;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_RUN;
            m_q          <= '0;
            wb_q         <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            wb_q         <= wb_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

endmodule
